// File: rtl/data_sync_pkg.sv
// Shared definitions for the data_sync bus synchroniser slice.
// Holds default geometry, the enable-mode encoding and the edge-detect rule.
package data_sync_pkg;

    localparam int unsigned DEF_BUS_WIDTH  = 8;
    localparam int unsigned DEF_NUM_STAGES = 2;
    localparam int unsigned DEF_CNT_WIDTH  = 4;

    // Level: only a rising qualifier edge marks a transfer.
    // Toggle: every qualifier change marks a transfer.
    typedef enum logic {
        EN_LEVEL  = 1'b0,
        EN_TOGGLE = 1'b1
    } en_mode_e;

    // Transfer strobe from the synchronised qualifier and its one-cycle-old copy.
    function automatic logic edge_detect(en_mode_e mode, logic en_sync, logic en_prev);
        logic hit;
        hit = 1'b0;
        if (mode == EN_TOGGLE) begin
            hit = en_sync ^ en_prev;
        end else begin
            hit = en_sync & ~en_prev;
        end
        return hit;
    endfunction

endpackage : data_sync_pkg

// File: rtl/data_sync_if.sv
// Bus bundle between a source-domain producer and the data_sync block.
//   UNSYNC_BUS   : source data, quasi-static while a transfer is in flight
//   BUS_ENABLE   : source qualifier (level or toggle)
//   SYNC_BUS     : destination-domain data holding register
//   ENABLE_PULSE : one-cycle strobe coincident with a SYNC_BUS load
//   XFER_CNT     : wrap-around count of completed transfers
// master = producer/observer side, slave = data_sync side.
interface data_sync_if
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);

    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_ENABLE;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;
    logic [CNT_WIDTH-1:0] XFER_CNT;

    modport master (
        output UNSYNC_BUS,
        output BUS_ENABLE,
        input  SYNC_BUS,
        input  ENABLE_PULSE,
        input  XFER_CNT
    );

    modport slave (
        input  UNSYNC_BUS,
        input  BUS_ENABLE,
        output SYNC_BUS,
        output ENABLE_PULSE,
        output XFER_CNT
    );

endinterface : data_sync_if

// File: rtl/data_sync_bit_sync.sv
// Per-bit multi-flop synchroniser into the clk domain.
//   clk        : destination clock
//   rst_n      : asynchronous active-low reset, clears every stage
//   unsync_bus : asynchronous input bits
//   sync_bus   : output of the last stage
// Each bit is synchronised independently; no cross-bit coherency is implied.
module data_sync_bit_sync #(
    parameter int unsigned BUS_WIDTH  = 1,
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    output logic [BUS_WIDTH-1:0] sync_bus
);

    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stage_q;
    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stage_d;

    // Shift chain: stage 0 captures the raw input, later stages follow.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = unsync_bus;
        for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_bus = stage_q[NUM_STAGES-1];

endmodule : data_sync_bit_sync

// File: rtl/data_sync.sv
// Coherent multi-bit CDC bus synchroniser, destination-domain only.
//   CLK  : destination clock
//   RST  : asynchronous active-low reset
//   bus  : data_sync_if slave port
//          in : UNSYNC_BUS, BUS_ENABLE
//          out: SYNC_BUS, ENABLE_PULSE, XFER_CNT (all registered)
// Only BUS_ENABLE crosses through the synchroniser chain. A detected edge of
// the synchronised qualifier loads the quasi-static UNSYNC_BUS into the
// holding register, fires a one-cycle strobe and bumps the transfer count.
module data_sync
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
    parameter int unsigned TOGGLE_MODE = 0,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic        CLK,
    input  logic        RST,
    data_sync_if.slave  bus
);

    localparam en_mode_e MODE = (TOGGLE_MODE != 0) ? EN_TOGGLE : EN_LEVEL;

    logic                 en_sync;
    logic                 pulse_c;

    logic                 en_prev_q;
    logic                 en_prev_d;
    logic [BUS_WIDTH-1:0] sync_bus_q;
    logic [BUS_WIDTH-1:0] sync_bus_d;
    logic                 enable_pulse_q;
    logic                 enable_pulse_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q;
    logic [CNT_WIDTH-1:0] xfer_cnt_d;

    // Qualifier synchroniser; the data bus itself is never synchronised.
    data_sync_bit_sync #(
        .BUS_WIDTH  (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .clk        (CLK),
        .rst_n      (RST),
        .unsync_bus (bus.BUS_ENABLE),
        .sync_bus   (en_sync)
    );

    // Edge detect, data capture mux and transfer counter.
    // In level mode en_prev follows en_sync, so a held-high qualifier can
    // only ever produce a single-cycle strobe.
    always_comb begin
        en_prev_d      = en_sync;
        sync_bus_d     = sync_bus_q;
        enable_pulse_d = 1'b0;
        xfer_cnt_d     = xfer_cnt_q;
        pulse_c        = edge_detect(MODE, en_sync, en_prev_q);

        if (pulse_c) begin
            sync_bus_d     = bus.UNSYNC_BUS;
            enable_pulse_d = 1'b1;
            xfer_cnt_d     = xfer_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Reset drops any in-flight transfer: the chain and en_prev clear together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            en_prev_q      <= 1'b0;
            sync_bus_q     <= '0;
            enable_pulse_q <= 1'b0;
            xfer_cnt_q     <= '0;
        end else begin
            en_prev_q      <= en_prev_d;
            sync_bus_q     <= sync_bus_d;
            enable_pulse_q <= enable_pulse_d;
            xfer_cnt_q     <= xfer_cnt_d;
        end
    end

    assign bus.SYNC_BUS     = sync_bus_q;
    assign bus.ENABLE_PULSE = enable_pulse_q;
    assign bus.XFER_CNT     = xfer_cnt_q;

endmodule : data_sync
